// File: rtl/divu_seq.sv
// divu_seq: sequential restoring divider, one quotient bit per clock.
// Signed mode truncates toward zero; remainder takes the dividend's sign.
module divu_seq #(
  parameter int BW_CNT  = 3,
  parameter int BW_DVND = 4,
  parameter int BW_DVSR = 3
) (
  input  logic               clk,
  input  logic               rstx,
  input  logic               is_signed,
  input  logic               start,
  input  logic [BW_DVND-1:0] dvnd,
  input  logic [BW_DVSR-1:0] dvsr,
  output logic [BW_DVND-1:0] quot,
  output logic [BW_DVSR-1:0] rem,
  output logic               div_by_zero,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t             state_q;
  logic [BW_CNT-1:0]  cnt_q;
  logic [BW_DVSR:0]   prem_q;
  logic [BW_DVND-1:0] dv_q;
  logic [BW_DVSR-1:0] ds_q;
  logic [BW_DVSR-1:0] dlow_q;
  logic               qneg_q;
  logic               rneg_q;
  logic               zero_q;
  logic [BW_DVND-1:0] quot_q;
  logic [BW_DVSR-1:0] rem_q;
  logic               dbz_q;
  logic               busy_q;

  logic               dvnd_neg;
  logic               dvsr_neg;
  logic [BW_DVND-1:0] dvnd_mag;
  logic [BW_DVSR-1:0] dvsr_mag;
  logic [BW_DVSR:0]   shl;
  logic [BW_DVSR:0]   diff;
  logic               ge;
  logic [BW_DVSR:0]   prem_d;
  logic [BW_DVND-1:0] dv_d;
  logic [BW_DVSR-1:0] rmag;
  logic [BW_DVND-1:0] quot_d;
  logic [BW_DVSR-1:0] rem_d;

  always_comb begin
    dvnd_neg = is_signed & dvnd[BW_DVND-1];
    dvsr_neg = is_signed & dvsr[BW_DVSR-1];
    dvnd_mag = dvnd_neg ? -dvnd : dvnd;
    dvsr_mag = dvsr_neg ? -dvsr : dvsr;
  end

  // Partial remainder stays below the divisor, so the shift fits BW_DVSR+1.
  always_comb begin
    shl    = {prem_q[BW_DVSR-1:0], dv_q[BW_DVND-1]};
    diff   = shl - {1'b0, ds_q};
    ge     = shl >= {1'b0, ds_q};
    prem_d = ge ? diff : shl;
    dv_d   = {dv_q[BW_DVND-2:0], ge};
  end

  always_comb begin
    rmag   = prem_q[BW_DVSR-1:0];
    quot_d = qneg_q ? -dv_q : dv_q;
    rem_d  = rneg_q ? -rmag : rmag;
    if (zero_q) begin
      quot_d = '1;
      rem_d  = dlow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstx) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dv_q    <= '0;
      ds_q    <= '0;
      dlow_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start) begin
      state_q <= CALC;
      busy_q  <= 1'b1;
      cnt_q   <= BW_CNT'(BW_DVND);
      prem_q  <= '0;
      dv_q    <= dvnd_mag;
      ds_q    <= dvsr_mag;
      dlow_q  <= dvnd[BW_DVSR-1:0];
      qneg_q  <= dvnd_neg ^ dvsr_neg;
      rneg_q  <= dvnd_neg;
      zero_q  <= (dvsr == '0);
    end else begin
      unique case (state_q)
        CALC: begin
          prem_q <= prem_d;
          dv_q   <= dv_d;
          cnt_q  <= cnt_q - BW_CNT'(1);
          if (cnt_q == BW_CNT'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quot_q  <= quot_d;
          rem_q   <= rem_d;
          dbz_q   <= zero_q;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_divu_seq.sv
// tb_divu_seq: directed and random checks of divu_seq against an
// integer-arithmetic reference model.
module tb_divu_seq;

  logic       clk = 1'b0;
  logic       rstx = 1'b0;
  logic       is_signed = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dvnd = '0;
  logic [2:0] dvsr = '0;
  logic [3:0] quot;
  logic [2:0] rem;
  logic       div_by_zero;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [3:0] eq = '0;
  logic [2:0] er = '0;
  logic       ez = 1'b0;

  always #5 clk = ~clk;

  divu_seq #(
    .BW_CNT (3),
    .BW_DVND(4),
    .BW_DVSR(3)
  ) dut (
    .clk        (clk),
    .rstx       (rstx),
    .is_signed  (is_signed),
    .start      (start),
    .dvnd       (dvnd),
    .dvsr       (dvsr),
    .quot       (quot),
    .rem        (rem),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // C semantics: integer / and % truncate toward zero.
  task automatic model(input bit s,
                       input logic [3:0] a,
                       input logic [2:0] b,
                       output logic [3:0] q,
                       output logic [2:0] r,
                       output logic z);
    int ai, bi;
    if (b == 3'd0) begin
      q = 4'hF;
      r = a[2:0];
      z = 1'b1;
    end else begin
      ai = s ? int'($signed(a)) : int'(a);
      bi = s ? int'($signed(b)) : int'(b);
      q = 4'(ai / bi);
      r = 3'(ai % bi);
      z = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the negedge of busy cycle 1.
  task automatic launch(input bit s,
                        input logic [3:0] a,
                        input logic [2:0] b);
    is_signed = s;
    dvnd = a;
    dvsr = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    is_signed = 1'($urandom);
    dvnd = 4'($urandom);
    dvsr = 3'($urandom);
  endtask

  task automatic hold_chk();
    chk("hold_busy", busy, 1);
    chk("hold_quot", quot, eq);
    chk("hold_rem", rem, er);
    chk("hold_dbz", div_by_zero, ez);
  endtask

  task automatic finish_div(input bit s,
                            input logic [3:0] a,
                            input logic [2:0] b);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      chk("hold_quot", quot, eq);
      chk("hold_rem", rem, er);
      chk("hold_dbz", div_by_zero, ez);
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 5);
    model(s, a, b, eq, er, ez);
    chk("quot", quot, eq);
    chk("rem", rem, er);
    chk("dbz", div_by_zero, ez);
  endtask

  task automatic run_div(input bit s,
                         input logic [3:0] a,
                         input logic [2:0] b);
    launch(s, a, b);
    finish_div(s, a, b);
  endtask

  initial begin
    bit s, s2;
    logic [3:0] a, a2;
    logic [2:0] b, b2;
    int k;

    rstx = 1'b0;
    start = 1'b1;
    dvnd = 4'd13;
    dvsr = 3'd3;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dbz", div_by_zero, 0);
    rstx = 1'b1;
    @(negedge clk);

    run_div(1'b0, 4'd13, 3'd3);
    chk("tp1_quot", quot, 4'd4);
    chk("tp1_rem", rem, 3'd1);
    run_div(1'b1, 4'b1001, 3'b010);
    chk("tp2a_quot", quot, 4'b1101);
    chk("tp2a_rem", rem, 3'b111);
    run_div(1'b1, 4'd7, 3'b101);
    chk("tp2b_quot", quot, 4'b1110);
    chk("tp2b_rem", rem, 3'b001);
    run_div(1'b1, 4'b1000, 3'b111);
    chk("tp3a_quot", quot, 4'b1000);
    chk("tp3a_rem", rem, 3'b000);
    chk("tp3a_dbz", div_by_zero, 0);
    run_div(1'b0, 4'd15, 3'd7);
    chk("tp3b_quot", quot, 4'd2);
    run_div(1'b0, 4'd9, 3'd0);
    chk("tp4a_quot", quot, 4'b1111);
    chk("tp4a_rem", rem, 3'b001);
    chk("tp4a_dbz", div_by_zero, 1);
    run_div(1'b0, 4'd6, 3'd2);
    chk("tp4b_quot", quot, 4'd3);
    chk("tp4b_dbz", div_by_zero, 0);

    launch(1'b0, 4'd13, 3'd3);
    hold_chk();
    @(negedge clk);
    launch(1'b0, 4'd10, 3'd4);
    finish_div(1'b0, 4'd10, 3'd4);
    chk("tp5_quot", quot, 4'd2);
    chk("tp5_rem", rem, 3'd2);

    launch(1'b0, 4'd11, 3'd2);
    @(negedge clk);
    rstx = 1'b0;
    @(negedge clk);
    rstx = 1'b1;
    chk("tp6_busy", busy, 0);
    chk("tp6_quot", quot, 0);
    chk("tp6_rem", rem, 0);
    chk("tp6_dbz", div_by_zero, 0);
    eq = '0;
    er = '0;
    ez = 1'b0;
    @(negedge clk);
    chk("tp6_idle", busy, 0);
    rstx = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("tp6_rs_busy", busy, 0);
    rstx = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("tp6_rs_idle", busy, 0);
    chk("tp6_rs_quot", quot, 0);

    for (int i = 0; i < 300; i++) begin
      s = 1'($urandom);
      a = 4'($urandom);
      b = 3'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        s2 = 1'($urandom);
        a2 = 4'($urandom);
        b2 = 3'($urandom);
        launch(s2, a2, b2);
        k = $urandom_range(0, 4);
        for (int j = 0; j < k; j++) begin
          hold_chk();
          @(negedge clk);
        end
      end
      run_div(s, a, b);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
